intr_ctrl: RTL and testbench
============================

# intr_ctrl

Multi-source interrupt controller replacing the single `intr_en`/`intr_vec` pair in the CPU state. It sits between the mother board's interrupt sources (UART RX, timer, and similar) and the CPU core. It holds the interrupt CSRs written by `w_intr` and read by `r_intr`, latches and prioritises up to `NUM_SRC` requests, and presents one vectored request to the CPU with an ack/return handshake.

## Interface
Parameters:
- `NUM_SRC`, 4: number of interrupt sources, 1..16.
- `XLEN`, 32: CSR data width.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous reset, active-low.
- `src` in NUM_SRC: raw interrupt sources, synchronous to `clk`.
- `w_en` in 1: CSR write strobe from `w_intr`.
- `w_addr` in 4: CSR index (the `imm[3:0]` field).
- `w_data` in XLEN: CSR write data (`x[rs1]`).
- `r_addr` in 4: CSR read index.
- `r_data` out XLEN: CSR read data, combinational.
- `irq_req` out 1: interrupt request to the CPU, registered.
- `irq_id` out 4: index of the requesting source, registered.
- `irq_vec` out XLEN: jump target, registered.
- `irq_ack` in 1: single-cycle pulse, CPU has taken the request.
- `irq_ret` in 1: single-cycle pulse, CPU executed the interrupt return.
- `intr_en` out 1: current global enable.

## Operation
CSR map. Indices not listed read as 0 and ignore writes. Bits at or above NUM_SRC read as 0.
- 1 `EN`: global enable, bit 0.
- 2 `VEC`: vector base, full XLEN.
- 3 `MASK`: per-source enable.
- 4 `PEND`: pending flags. Reads return the flags. Writing 1 to a bit clears it; writing 0 leaves it unchanged.
- 5 `EDGE`: per-source mode. 1 = rising-edge, 0 = level.
- 6 `PREV_EN`: EN value saved at ack, read-only.

Source capture:
- `src_q` holds `src` from the previous cycle.
- Edge mode: set `PEND[i]` on `src[i] & ~src_q[i]`.
- Level mode: set `PEND[i]` whenever `src[i]` is 1.
- Capture is independent of MASK and EN.

Selection:
- `cand = PEND & MASK`.
- The winner is the lowest set index; index 0 has highest priority.
- Vector: `VEC + (id << 2)`, truncated to XLEN.

State machine, states IDLE, REQ, SERVICE:
- IDLE -> REQ when `EN & |cand`. Register `irq_req=1` plus `irq_id` and `irq_vec` of the winner.
- REQ: re-evaluate the winner every cycle so a higher-priority arrival replaces `irq_id` and `irq_vec`.
  - If `cand` becomes 0 or EN becomes 0, go to IDLE and drop `irq_req`.
- REQ + `irq_ack`: go to SERVICE.
  - `PREV_EN<=EN`, `EN<=0`, `irq_req<=0`.
  - Clear `PEND[irq_id]` if that source is in edge mode; a level source stays pending until it deasserts.
  - `irq_id` and `irq_vec` hold their value.
- SERVICE + `irq_ret`: go to IDLE with `EN<=PREV_EN`.
- `irq_ack` outside REQ and `irq_ret` outside SERVICE are ignored.

Simultaneous events:
- Source set and W1C clear of the same PEND bit in one cycle: set wins.
- `irq_ack` and a CSR write to EN in one cycle: ack wins, EN=0. PREV_EN takes the pre-write EN.
- `irq_ret` and a CSR write to EN in one cycle: ret wins.
- Writes to MASK or VEC during REQ take effect on the next evaluation.

## Timing
- Reset values: all CSRs 0, `src_q`=0, state IDLE, `irq_req`=0, `irq_id`=0, `irq_vec`=0, `intr_en`=0. `r_data` is determined by `r_addr`.
- CSR write is visible on `r_data` and `intr_en` the cycle after the `w_en` edge.
- Source to PEND: the PEND bit is set at the first rising edge where `src` meets the capture condition.
- PEND to `irq_req`: 1 cycle. Worst case from `src` to `irq_req` is 2 edges.
- Ack: `irq_req` is 0 the cycle after `irq_ack`. A ret takes effect at the next edge.
- Reset asserted mid-service: the block returns to the reset values at the next edge and the source history is lost.

## Test plan
- CSR write and read: write EN=1, then VEC=7. Required: `intr_en`=1, `r_data`(2)=7, and index 7 reads 0.
- Priority: EN=1, VEC=0x100, MASK=0b1010, EDGE=0b1111; pulse `src[3]` and `src[1]` in the same cycle. Required: `irq_req` 2 cycles later with `irq_id`=1 and `irq_vec`=0x104.
- Ack and return: from the priority case, pulse `irq_ack`.
  - Required after ack: `irq_req`=0, EN=0, PREV_EN=1, PEND=0b1000.
  - Pulse `irq_ret`. Required: EN=1, then `irq_req` with `irq_id`=3 and `irq_vec`=0x10C.
- Level source: EDGE=0, MASK=1, hold `src[0]` high through ack and ret. Required: PEND[0] stays 1 and the request is re-raised after ret. Drop `src[0]` and W1C PEND. Required: PEND reads 0.
- Collision: W1C of PEND[2] in the same cycle as an edge on `src[2]`. Required: PEND[2]=1.
- Reset mid-SERVICE: assert `reset` low for one edge. Required: all outputs and CSRs 0, state IDLE, and no request until EN is rewritten.

Source files
------------

// File: rtl/intr_ctrl_if.sv
// rtl/intr_ctrl_if.sv - CSR access and interrupt handshake bundle between CPU core and intr_ctrl
//
// Signals:
//   w_en/w_addr/w_data   CSR write strobe, index and data (from the CPU)
//   r_addr/r_data        CSR read index (from the CPU) and combinational read data
//   irq_req/irq_id/irq_vec  registered vectored request towards the CPU
//   irq_ack/irq_ret      single-cycle take and return pulses from the CPU
//   intr_en              current global enable
// master = CPU side, slave = interrupt controller side.

interface intr_ctrl_if #(
    parameter int XLEN = 32
);
    logic            w_en;
    logic [3:0]      w_addr;
    logic [XLEN-1:0] w_data;
    logic [3:0]      r_addr;
    logic [XLEN-1:0] r_data;
    logic            irq_req;
    logic [3:0]      irq_id;
    logic [XLEN-1:0] irq_vec;
    logic            irq_ack;
    logic            irq_ret;
    logic            intr_en;

    modport master (
        output w_en, w_addr, w_data, r_addr, irq_ack, irq_ret,
        input  r_data, irq_req, irq_id, irq_vec, intr_en
    );

    modport slave (
        input  w_en, w_addr, w_data, r_addr, irq_ack, irq_ret,
        output r_data, irq_req, irq_id, irq_vec, intr_en
    );
endinterface

// File: rtl/intr_ctrl.sv
// rtl/intr_ctrl.sv - multi-source vectored interrupt controller with CSR block
//
// Ports:
//   clk     in   rising-edge clock
//   reset   in   synchronous reset, active low
//   src     in   NUM_SRC raw interrupt sources, synchronous to clk
//   bus     slave modport of intr_ctrl_if (CSR write/read, irq request/ack/return, intr_en)
//
// CSR indices: 1 EN, 2 VEC, 3 MASK, 4 PEND (write-1-to-clear), 5 EDGE, 6 PREV_EN (read-only).

module intr_ctrl #(
    parameter int NUM_SRC = 4,
    parameter int XLEN    = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src,
    intr_ctrl_if.slave         bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam logic [3:0] A_EN      = 4'd1;
    localparam logic [3:0] A_VEC     = 4'd2;
    localparam logic [3:0] A_MASK    = 4'd3;
    localparam logic [3:0] A_PEND    = 4'd4;
    localparam logic [3:0] A_EDGE    = 4'd5;
    localparam logic [3:0] A_PREV_EN = 4'd6;

    state_t             state;
    logic               en;
    logic               prev_en;
    logic [XLEN-1:0]    vec;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] pend;
    logic [NUM_SRC-1:0] edge_mode;
    logic [NUM_SRC-1:0] src_q;

    logic               irq_req_q;
    logic [3:0]         irq_id_q;
    logic [XLEN-1:0]    irq_vec_q;

    logic [NUM_SRC-1:0] cand;
    logic [NUM_SRC-1:0] src_set;
    logic [NUM_SRC-1:0] ack_clr;
    logic [NUM_SRC-1:0] pend_nxt;
    logic [3:0]         win_id;
    logic [XLEN-1:0]    win_vec;
    logic               take_ack;

    logic wr_en_csr;
    logic wr_vec;
    logic wr_mask;
    logic wr_pend;
    logic wr_edge;

    assign wr_en_csr = bus.w_en && (bus.w_addr == A_EN);
    assign wr_vec    = bus.w_en && (bus.w_addr == A_VEC);
    assign wr_mask   = bus.w_en && (bus.w_addr == A_MASK);
    assign wr_pend   = bus.w_en && (bus.w_addr == A_PEND);
    assign wr_edge   = bus.w_en && (bus.w_addr == A_EDGE);

    assign take_ack  = (state == REQ) && bus.irq_ack;

    // Edge-mode sources latch only on a 0->1 transition; level-mode sources
    // latch on every cycle they are high, so they re-pend after a W1C.
    assign src_set   = src & ~(edge_mode & src_q);
    assign cand      = pend & mask;

    // Only the source being acknowledged is cleared, and only when it is an
    // edge source; a level source must be cleared by software once it drops.
    assign ack_clr   = take_ack ? ((NUM_SRC'(1) << irq_id_q) & edge_mode) : '0;

    // Clears are applied first so that a capture in the same cycle survives.
    always_comb begin
        pend_nxt = pend;
        if (wr_pend) begin
            pend_nxt = pend_nxt & ~bus.w_data[NUM_SRC-1:0];
        end
        pend_nxt = pend_nxt & ~ack_clr;
        pend_nxt = pend_nxt | src_set;
    end

    // Lowest set index wins: scanning downward leaves the lowest hit last.
    always_comb begin
        win_id = 4'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win_id = 4'(i);
            end
        end
    end

    assign win_vec = vec + (XLEN'(win_id) << 2);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            en        <= 1'b0;
            prev_en   <= 1'b0;
            vec       <= '0;
            mask      <= '0;
            pend      <= '0;
            edge_mode <= '0;
            src_q     <= '0;
            irq_req_q <= 1'b0;
            irq_id_q  <= 4'd0;
            irq_vec_q <= '0;
        end else begin
            src_q <= src;
            pend  <= pend_nxt;

            if (wr_vec) begin
                vec <= bus.w_data;
            end
            if (wr_mask) begin
                mask <= bus.w_data[NUM_SRC-1:0];
            end
            if (wr_edge) begin
                edge_mode <= bus.w_data[NUM_SRC-1:0];
            end
            // Software EN write is the default; ack and ret below override it
            // because their assignments come later in this block.
            if (wr_en_csr) begin
                en <= bus.w_data[0];
            end

            case (state)
                IDLE: begin
                    if (en && (cand != '0)) begin
                        state     <= REQ;
                        irq_req_q <= 1'b1;
                        irq_id_q  <= win_id;
                        irq_vec_q <= win_vec;
                    end
                end
                REQ: begin
                    if (bus.irq_ack) begin
                        state     <= SERVICE;
                        irq_req_q <= 1'b0;
                        prev_en   <= en;
                        en        <= 1'b0;
                    end else if (!en || (cand == '0)) begin
                        state     <= IDLE;
                        irq_req_q <= 1'b0;
                    end else begin
                        irq_id_q  <= win_id;
                        irq_vec_q <= win_vec;
                    end
                end
                SERVICE: begin
                    if (bus.irq_ret) begin
                        state <= IDLE;
                        en    <= prev_en;
                    end
                end
                default: begin
                    state     <= IDLE;
                    irq_req_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        bus.r_data = '0;
        case (bus.r_addr)
            A_EN:      bus.r_data = XLEN'(en);
            A_VEC:     bus.r_data = vec;
            A_MASK:    bus.r_data = XLEN'(mask);
            A_PEND:    bus.r_data = XLEN'(pend);
            A_EDGE:    bus.r_data = XLEN'(edge_mode);
            A_PREV_EN: bus.r_data = XLEN'(prev_en);
            default:   bus.r_data = '0;
        endcase
    end

    assign bus.irq_req = irq_req_q;
    assign bus.irq_id  = irq_id_q;
    assign bus.irq_vec = irq_vec_q;
    assign bus.intr_en = en;

endmodule

// File: tb/tb_intr_ctrl.sv
// tb/tb_intr_ctrl.sv - self-checking bench for intr_ctrl

module tb_intr_ctrl;

    localparam int NS = 4;
    localparam int XL = 32;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic [NS-1:0] src   = '0;

    intr_ctrl_if #(.XLEN(XL)) bus ();

    intr_ctrl #(.NUM_SRC(NS), .XLEN(XL)) dut (
        .clk   (clk),
        .reset (reset),
        .src   (src),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: CSR contents plus two flags, "a request is being
    // presented" and "the CPU is inside a handler".
    bit          m_live = 0;
    bit          m_en, m_prev, m_req, m_busy;
    logic [31:0] m_vec, m_ivec;
    logic [3:0]  m_mask, m_pend, m_edge, m_srcq, m_id;

    function automatic logic [3:0] lowest_id(input logic [3:0] c);
        logic [3:0] low;
        low = c & (~c + 4'd1);
        return 4'($clog2(int'(low)));
    endfunction

    function automatic logic [31:0] m_read(input logic [3:0] a);
        case (a)
            4'd1:    return {31'd0, m_en};
            4'd2:    return m_vec;
            4'd3:    return {28'd0, m_mask};
            4'd4:    return {28'd0, m_pend};
            4'd5:    return {28'd0, m_edge};
            4'd6:    return {31'd0, m_prev};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin : model
        logic [3:0] setv, cand, newpend;
        bit         take_ack, take_ret;
        if (!reset) begin
            m_en = 0; m_prev = 0; m_req = 0; m_busy = 0;
            m_vec = 0; m_ivec = 0; m_mask = 0; m_pend = 0;
            m_edge = 0; m_srcq = 0; m_id = 0;
            m_live = 1;
        end else begin
            for (int i = 0; i < NS; i++) begin
                if (m_edge[i]) setv[i] = src[i] && !m_srcq[i];
                else           setv[i] = src[i];
            end
            cand     = m_pend & m_mask;
            take_ack = m_req && bus.irq_ack;
            take_ret = m_busy && bus.irq_ret;

            newpend = m_pend;
            if (bus.w_en && bus.w_addr == 4'd4) newpend = newpend & ~bus.w_data[3:0];
            if (take_ack && m_edge[m_id[1:0]]) newpend[m_id[1:0]] = 1'b0;
            newpend = newpend | setv;

            if (take_ack) begin
                m_req  = 0;
                m_busy = 1;
            end else if (take_ret) begin
                m_busy = 0;
            end else if (!m_busy) begin
                if (m_en && cand != 0) begin
                    m_req  = 1;
                    m_id   = lowest_id(cand);
                    m_ivec = m_vec + ({28'd0, m_id} * 32'd4);
                end else begin
                    m_req = 0;
                end
            end

            if (take_ack) begin
                m_prev = m_en;
                m_en   = 0;
            end else if (take_ret) begin
                m_en = m_prev;
            end else if (bus.w_en && bus.w_addr == 4'd1) begin
                m_en = bus.w_data[0];
            end
            if (bus.w_en && bus.w_addr == 4'd2) m_vec  = bus.w_data;
            if (bus.w_en && bus.w_addr == 4'd3) m_mask = bus.w_data[3:0];
            if (bus.w_en && bus.w_addr == 4'd5) m_edge = bus.w_data[3:0];
            m_pend = newpend;
            m_srcq = src;
        end
    end

    always @(posedge clk) begin : compare
        #2;
        if (m_live) begin
            chk("cyc_irq_req", {31'd0, bus.irq_req}, {31'd0, m_req});
            chk("cyc_irq_id",  {28'd0, bus.irq_id},  {28'd0, m_id});
            chk("cyc_irq_vec", bus.irq_vec, m_ivec);
            chk("cyc_intr_en", {31'd0, bus.intr_en}, {31'd0, m_en});
            chk("cyc_r_data",  bus.r_data, m_read(bus.r_addr));
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus.w_en   = 1'b1;
        bus.w_addr = a;
        bus.w_data = d;
        step();
        bus.w_en   = 1'b0;
    endtask

    task automatic rd(input string nm, input logic [3:0] a, input logic [31:0] exp);
        bus.r_addr = a;
        #1;
        chk(nm, bus.r_data, exp);
    endtask

    task automatic pulse_ack();
        bus.irq_ack = 1'b1;
        step();
        bus.irq_ack = 1'b0;
    endtask

    task automatic pulse_ret();
        bus.irq_ret = 1'b1;
        step();
        bus.irq_ret = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog run did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.w_en = 0; bus.w_addr = 0; bus.w_data = 0; bus.r_addr = 0;
        bus.irq_ack = 0; bus.irq_ret = 0;
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        chk("rst_irq_req", {31'd0, bus.irq_req}, 32'd0);
        chk("rst_intr_en", {31'd0, bus.intr_en}, 32'd0);
        rd("rst_vec", 4'd2, 32'd0);

        // CSR write and read
        wr(4'd1, 32'd1);
        chk("csr_intr_en", {31'd0, bus.intr_en}, 32'd1);
        wr(4'd2, 32'd7);
        rd("csr_vec", 4'd2, 32'd7);
        rd("csr_idx7", 4'd7, 32'd0);

        // Priority
        wr(4'd2, 32'h100);
        wr(4'd3, 32'hA);
        wr(4'd5, 32'hF);
        src = 4'b1010;
        step();
        src = 4'b0000;
        chk("pri_no_req_yet", {31'd0, bus.irq_req}, 32'd0);
        step();
        chk("pri_irq_req", {31'd0, bus.irq_req}, 32'd1);
        chk("pri_irq_id",  {28'd0, bus.irq_id}, 32'd1);
        chk("pri_irq_vec", bus.irq_vec, 32'h104);

        // Ack and return
        pulse_ack();
        chk("ack_irq_req", {31'd0, bus.irq_req}, 32'd0);
        chk("ack_intr_en", {31'd0, bus.intr_en}, 32'd0);
        rd("ack_prev_en", 4'd6, 32'd1);
        rd("ack_pend", 4'd4, 32'h8);
        pulse_ret();
        chk("ret_intr_en", {31'd0, bus.intr_en}, 32'd1);
        step();
        chk("ret_irq_req", {31'd0, bus.irq_req}, 32'd1);
        chk("ret_irq_id",  {28'd0, bus.irq_id}, 32'd3);
        chk("ret_irq_vec", bus.irq_vec, 32'h10C);
        pulse_ack();
        pulse_ret();

        // Level source
        wr(4'd5, 32'd0);
        wr(4'd3, 32'd1);
        src = 4'b0001;
        step();
        step();
        chk("lvl_irq_req", {31'd0, bus.irq_req}, 32'd1);
        chk("lvl_irq_id",  {28'd0, bus.irq_id}, 32'd0);
        pulse_ack();
        rd("lvl_pend_held", 4'd4, 32'd1);
        pulse_ret();
        step();
        chk("lvl_rereq", {31'd0, bus.irq_req}, 32'd1);
        src = 4'b0000;
        pulse_ack();
        rd("lvl_pend_sticky", 4'd4, 32'd1);
        wr(4'd4, 32'd1);
        rd("lvl_pend_w1c", 4'd4, 32'd0);
        pulse_ret();
        step();
        chk("lvl_no_req", {31'd0, bus.irq_req}, 32'd0);

        // Collision of capture and W1C on the same bit
        wr(4'd5, 32'h4);
        src = 4'b0100;
        wr(4'd4, 32'h4);
        src = 4'b0000;
        rd("col_pend_set_wins", 4'd4, 32'h4);
        wr(4'd4, 32'h4);
        rd("col_pend_cleared", 4'd4, 32'd0);

        // Reset while in SERVICE
        wr(4'd3, 32'h4);
        src = 4'b0100;
        step();
        src = 4'b0000;
        step();
        chk("svc_irq_id",  {28'd0, bus.irq_id}, 32'd2);
        chk("svc_irq_vec", bus.irq_vec, 32'h108);
        pulse_ack();
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("mrst_irq_req", {31'd0, bus.irq_req}, 32'd0);
        chk("mrst_irq_id",  {28'd0, bus.irq_id}, 32'd0);
        chk("mrst_irq_vec", bus.irq_vec, 32'd0);
        chk("mrst_intr_en", {31'd0, bus.intr_en}, 32'd0);
        for (int a = 1; a <= 6; a++) begin
            rd($sformatf("mrst_csr%0d", a), 4'(a), 32'd0);
        end
        wr(4'd3, 32'hF);
        src = 4'b0001;
        step();
        step();
        chk("mrst_no_req_en0", {31'd0, bus.irq_req}, 32'd0);
        wr(4'd1, 32'd1);
        step();
        chk("mrst_req_after_en", {31'd0, bus.irq_req}, 32'd1);
        chk("mrst_req_vec", bus.irq_vec, 32'd0);

        // VEC write during REQ is picked up on the following evaluation
        wr(4'd2, 32'hFFFF_FFFC);
        chk("vec_old_held", bus.irq_vec, 32'd0);
        step();
        chk("vec_new", bus.irq_vec, 32'hFFFF_FFFC);

        // Ack together with EN write: ack wins, PREV_EN keeps pre-write EN
        bus.irq_ack = 1'b1;
        wr(4'd1, 32'd1);
        bus.irq_ack = 1'b0;
        chk("ackw_intr_en", {31'd0, bus.intr_en}, 32'd0);
        rd("ackw_prev_en", 4'd6, 32'd1);

        // Ret together with EN write of 0: ret wins
        bus.irq_ret = 1'b1;
        wr(4'd1, 32'd0);
        bus.irq_ret = 1'b0;
        chk("retw_intr_en", {31'd0, bus.intr_en}, 32'd1);
        src = 4'b0000;
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
